lift_timer_arbiter: RTL and testbench

LIFT_TIMER_ARBITER -- requirements
Module: lift_timer_arbiter

---
 rtl/lift_timer_arbiter.sv | 148 ++++++++++++++
 tb/tb_lift_timer_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lift_timer_arbiter.sv
// Shared lift timer with 3-way round-robin ownership (door, travel, alarm).
// Optional prescaler compiled in with `define TIMER_PRESCALE_EN (PRESCALE clocks per tick).
`timescale 1ns/1ps
module lift_timer_arbiter #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned PRESCALE = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [CNT_W-1:0] dur0,
    input  logic [CNT_W-1:0] dur1,
    input  logic [CNT_W-1:0] dur2,
    output logic [2:0]       grant,
    output logic [2:0]       done,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state, w_state_d;
    logic [1:0]       r_idx, w_idx_d;
    logic [1:0]       r_ptr, w_ptr_d;
    logic [CNT_W-1:0] r_dur, w_dur_d;
    logic [CNT_W-1:0] r_count, w_count_d;

    logic [1:0]       w_c0, w_c1, w_c2;
    logic [1:0]       w_sel_idx;
    logic [CNT_W-1:0] w_sel_dur;
    logic [CNT_W-1:0] w_count_inc;
    logic [1:0]       w_ptr_next;
    logic [2:0]       w_gnt_oh;
    logic             w_owner_req;
    logic             w_tick;

    function automatic logic [1:0] wrap_inc(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Search order starts at the pointer and wraps 2 -> 0.
    assign w_c0 = r_ptr;
    assign w_c1 = wrap_inc(w_c0);
    assign w_c2 = wrap_inc(w_c1);

    always_comb begin
        if (req[w_c0]) begin
            w_sel_idx = w_c0;
        end else if (req[w_c1]) begin
            w_sel_idx = w_c1;
        end else begin
            w_sel_idx = w_c2;
        end
    end

    always_comb begin
        case (w_sel_idx)
            2'd0:    w_sel_dur = dur0;
            2'd1:    w_sel_dur = dur1;
            default: w_sel_dur = dur2;
        endcase
    end

    assign w_count_inc = r_count + CNT_W'(1);
    assign w_ptr_next  = wrap_inc(r_idx);
    assign w_gnt_oh    = 3'b001 << r_idx;
    assign w_owner_req = |(req & w_gnt_oh);

`ifdef TIMER_PRESCALE_EN
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0] r_pre;

    assign w_tick = (r_pre == PRE_W'(PRESCALE - 1));

    // Held at zero outside RUN, so every grant starts a fresh prescale period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (r_state != StRun || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_idx   <= 2'd0;
            r_ptr   <= 2'd0;
            r_dur   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            r_ptr   <= w_ptr_d;
            r_dur   <= w_dur_d;
            r_count <= w_count_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_ptr_d   = r_ptr;
        w_dur_d   = r_dur;
        w_count_d = r_count;
        case (r_state)
            StIdle: begin
                if (|req) begin
                    w_state_d = StRun;
                    w_idx_d   = w_sel_idx;
                    w_dur_d   = (w_sel_dur == '0) ? CNT_W'(1) : w_sel_dur;
                    w_count_d = '0;
                end
            end
            StRun: begin
                // Owner dropping its request wins over reaching terminal count.
                if (!w_owner_req) begin
                    w_state_d = StIdle;
                    w_ptr_d   = w_ptr_next;
                end else if (w_tick) begin
                    w_count_d = w_count_inc;
                    if (w_count_inc == r_dur) begin
                        w_state_d = StDone;
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
                w_ptr_d   = w_ptr_next;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign busy  = (r_state == StRun) || (r_state == StDone);
    assign grant = busy ? w_gnt_oh : 3'b000;
    assign done  = (r_state == StDone) ? w_gnt_oh : 3'b000;
    assign count = r_count;

endmodule

// File: tb/tb_lift_timer_arbiter.sv
// Directed bench for lift_timer_arbiter: per-cycle vector table plus hand sequences
// for async reset and grant-to-done latency (also runs with TIMER_PRESCALE_EN, PRESCALE=4).
`timescale 1ns/1ps
module tb_lift_timer_arbiter;

    localparam int unsigned CNT_W = 32;
`ifdef TIMER_PRESCALE_EN
    localparam int unsigned PRE_CFG = 4;
    localparam int unsigned TICKDIV = 4;
`else
    localparam int unsigned PRE_CFG = 100;
    localparam int unsigned TICKDIV = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       req = 3'b000;
    logic [CNT_W-1:0] dur0 = '0;
    logic [CNT_W-1:0] dur1 = '0;
    logic [CNT_W-1:0] dur2 = '0;
    logic [2:0]       grant;
    logic [2:0]       done;
    logic             busy;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_errors = 0;

    lift_timer_arbiter #(
        .CNT_W    (CNT_W),
        .PRESCALE (PRE_CFG)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .dur0  (dur0),
        .dur1  (dur1),
        .dur2  (dur2),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Structural invariants sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            check("done_in_grant", 32'(done & ~grant), 32'd0);
        end
    end

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [31:0] d0, d1, d2;
        logic [2:0]  g, dn;
        logic        b;
        logic        cc;
        logic [31:0] c;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic [2:0] rq, input int a0, input int a1,
                       input int a2, input logic [2:0] g, input logic [2:0] dn, input logic b,
                       input logic cc, input int c);
        vec_t v;
        v.rst = r; v.req = rq; v.d0 = 32'(a0); v.d1 = 32'(a1); v.d2 = 32'(a2);
        v.g = g; v.dn = dn; v.b = b; v.cc = cc; v.c = 32'(c);
        tv.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 3'b000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Grant-to-done latency: expect done exactly exp_cyc edges after the first grant cycle.
    task automatic latency(input logic [2:0] rq, input int d, input int exp_cyc);
        int cyc;
        do_reset();
        dur0 = 32'(d); dur1 = 32'(d); dur2 = 32'(d);
        req = rq;
        @(posedge clk); #1;
        check("lat_first_grant", 32'(grant), 32'(rq));
        cyc = 0;
        while (done === 3'b000 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("lat_cycles", 32'(cyc), 32'(exp_cyc));
        check("lat_done_bit", 32'(done), 32'(rq));
        check("lat_grant_held", 32'(grant), 32'(rq));
        @(negedge clk);
        req = 3'b000;
    endtask

    initial begin
        // Plain build: grant/done timing per cycle, one tick per clock.
        // done=5 case
        add(1, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 1, 0);
        add(0, 3'b001, 5, 0, 0, 3'b001, 3'b000, 1, 1, 0);
        add(0, 3'b001, 5, 0, 0, 3'b001, 3'b000, 1, 1, 1);
        add(0, 3'b001, 5, 0, 0, 3'b001, 3'b000, 1, 1, 2);
        add(0, 3'b001, 5, 0, 0, 3'b001, 3'b000, 1, 1, 3);
        add(0, 3'b001, 5, 0, 0, 3'b001, 3'b000, 1, 1, 4);
        add(0, 3'b001, 5, 0, 0, 3'b001, 3'b001, 1, 1, 5);
        add(0, 3'b000, 5, 0, 0, 3'b000, 3'b000, 0, 0, 0);
        // All three held, duration 2: round robin 0,1,2,0 with idle gaps
        add(1, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 1, 0);
        for (int r = 0; r < 4; r++) begin
            logic [2:0] gg;
            gg = 3'b001 << (r % 3);
            add(0, 3'b111, 2, 2, 2, gg, 3'b000, 1, 1, 0);
            add(0, 3'b111, 2, 2, 2, gg, 3'b000, 1, 1, 1);
            add(0, 3'b111, 2, 2, 2, gg, gg, 1, 1, 2);
            if (r < 3) add(0, 3'b111, 2, 2, 2, 3'b000, 3'b000, 0, 0, 0);
        end
        add(0, 3'b000, 2, 2, 2, 3'b000, 3'b000, 0, 0, 0);
        // Zero duration behaves as one tick
        add(1, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 1, 0);
        add(0, 3'b010, 0, 0, 0, 3'b010, 3'b000, 1, 1, 0);
        add(0, 3'b010, 0, 0, 0, 3'b010, 3'b010, 1, 1, 1);
        add(0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0);
        // Abort at count 4 with req[1] pending, then abort req[1] too
        add(1, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 1, 0);
        for (int k = 0; k < 5; k++) add(0, 3'b011, 10, 3, 0, 3'b001, 3'b000, 1, 1, k);
        add(0, 3'b010, 10, 3, 0, 3'b000, 3'b000, 0, 0, 0);
        add(0, 3'b010, 10, 3, 0, 3'b010, 3'b000, 1, 1, 0);
        add(0, 3'b000, 10, 3, 0, 3'b000, 3'b000, 0, 0, 0);

`ifndef TIMER_PRESCALE_EN
        foreach (tv[i]) begin
            @(negedge clk);
            rst = tv[i].rst; req = tv[i].req;
            dur0 = tv[i].d0; dur1 = tv[i].d1; dur2 = tv[i].d2;
            @(posedge clk); #1;
            check($sformatf("row%0d grant", i), 32'(grant), 32'(tv[i].g));
            check($sformatf("row%0d done", i), 32'(done), 32'(tv[i].dn));
            check($sformatf("row%0d busy", i), 32'(busy), 32'(tv[i].b));
            if (tv[i].cc) check($sformatf("row%0d count", i), count, tv[i].c);
        end

        // Async reset at count 7 of a 20-tick run
        do_reset();
        dur0 = 32'd20;
        req  = 3'b001;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (count == 32'd7) break;
        end
        check("ar_reach7", count, 32'd7);
        #1 rst = 1'b1;
        #1;
        check("ar_grant", 32'(grant), 32'd0);
        check("ar_done", 32'(done), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_count", count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ar_regrant", 32'(grant), 32'd1);
        check("ar_recount", count, 32'd0);
        @(negedge clk);
        req = 3'b000;
`endif

        latency(3'b001, 7, 7 * TICKDIV);
        latency(3'b100, 3, 3 * TICKDIV);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
